// File: rtl/noc_output_port_arbiter.sv
// rtl/noc_output_port_arbiter.sv - packet-level round-robin output-port arbiter with per-VC credit tracking
//
// Shares one router output link among NUM_IN input ports. A head flit wins the
// port and holds it until its tail flit; flits are forwarded only when the
// downstream VC buffer has a free slot.
//
// Ports:
//   noc_clk, noc_rst_n           clock, asynchronous active-low reset
//   req/req_vc/req_head/req_tail per-input flit request, VC (slice i), head/tail markers
//   gnt, out_valid, out_vc       one-hot transfer grant, link valid, VC of forwarded flit
//   credit_valid, credit_vc      one downstream slot freed on the given VC
//   credit_cnt                   registered credit per VC (VC v in slice v)
//   locked                       a packet owns the port
//   credit_err                   sticky credit overflow / out-of-range VC flag
module noc_output_port_arbiter #(
    parameter int NUM_IN    = 5,
    parameter int NUM_VC    = 2,
    parameter int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst_n,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN*VC_W-1:0]   req_vc,
    input  logic [NUM_IN-1:0]        req_head,
    input  logic [NUM_IN-1:0]        req_tail,
    output logic [NUM_IN-1:0]        gnt,
    output logic                     out_valid,
    output logic [VC_W-1:0]          out_vc,
    input  logic                     credit_valid,
    input  logic [VC_W-1:0]          credit_vc,
    output logic [NUM_VC*CNT_W-1:0]  credit_cnt,
    output logic                     locked,
    output logic                     credit_err
);

    localparam int IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int VC_SPACE = 1 << VC_W;

    // ST_GAP is the mandatory idle cycle after a locked packet's tail.
    typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_GAP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
    logic [CNT_W-1:0]  credit_q [NUM_VC];
    logic [CNT_W-1:0]  credit_d [NUM_VC];
    logic              credit_err_q, credit_err_d;

    logic [VC_SPACE-1:0] vc_has_credit;
    logic [VC_SPACE-1:0] vc_in_range;
    logic [NUM_IN-1:0]   gnt_raw;
    logic [VC_W-1:0]     vc_raw;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic                found;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_IN) s = s - NUM_IN;
        return IDX_W'(s);
    endfunction

    // Padded to the full VC index space so encodings >= NUM_VC read as "no credit".
    always_comb begin
        vc_has_credit = '0;
        vc_in_range   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_has_credit[v] = (credit_q[v] != '0);
            vc_in_range[v]   = 1'b1;
        end
    end

    always_comb begin
        gnt_raw = '0;
        vc_raw  = '0;
        win     = '0;
        cand    = '0;
        found   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    cand = wrap_add(rr_ptr_q, k);
                    if (!found && req[cand] && req_head[cand] &&
                        vc_has_credit[req_vc[cand*VC_W +: VC_W]]) begin
                        found        = 1'b1;
                        win          = cand;
                        gnt_raw[cand] = 1'b1;
                        vc_raw       = req_vc[cand*VC_W +: VC_W];
                    end
                end
            end
            ST_LOCKED: begin
                if (req[owner_q] && vc_has_credit[lock_vc_q]) begin
                    found          = 1'b1;
                    win            = owner_q;
                    gnt_raw[owner_q] = 1'b1;
                    vc_raw         = lock_vc_q;
                end
            end
            default: ;
        endcase
    end

    assign gnt       = noc_rst_n ? gnt_raw : '0;
    assign out_vc    = noc_rst_n ? vc_raw  : '0;
    assign out_valid = |gnt;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    rr_ptr_d = wrap_add(win, 1);
                    if (!req_tail[win]) begin
                        state_d   = ST_LOCKED;
                        owner_d   = win;
                        lock_vc_d = vc_raw;
                    end
                end
            end
            ST_LOCKED: begin
                if (found && req_tail[owner_q]) state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        credit_err_d = credit_err_q | (credit_valid & ~vc_in_range[credit_vc]);
        for (int v = 0; v < NUM_VC; v++) begin
            credit_d[v] = credit_q[v];
            if (found && (vc_raw == VC_W'(v)) && !(credit_valid && (credit_vc == VC_W'(v)))) begin
                credit_d[v] = credit_q[v] - CNT_W'(1);
            end else if (credit_valid && (credit_vc == VC_W'(v)) && !(found && (vc_raw == VC_W'(v)))) begin
                if (credit_q[v] == CNT_W'(BUF_DEPTH)) credit_err_d = 1'b1;
                else                                  credit_d[v]  = credit_q[v] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            lock_vc_q    <= '0;
            rr_ptr_q     <= '0;
            credit_err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CNT_W'(BUF_DEPTH);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lock_vc_q    <= lock_vc_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_err_q <= credit_err_d;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
        end
    end

    always_comb begin
        credit_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) credit_cnt[v*CNT_W +: CNT_W] = credit_q[v];
    end

    assign locked     = (state_q == ST_LOCKED);
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// tb/tb_noc_output_port_arbiter.sv - self-checking bench for noc_output_port_arbiter
module tb_noc_output_port_arbiter;

    localparam int NUM_IN    = 5;
    localparam int NUM_VC    = 2;
    localparam int VC_W      = 1;
    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_IN-1:0]       req;
    logic [NUM_IN*VC_W-1:0]  req_vc;
    logic [NUM_IN-1:0]       req_head;
    logic [NUM_IN-1:0]       req_tail;
    logic [NUM_IN-1:0]       gnt;
    logic                    out_valid;
    logic [VC_W-1:0]         out_vc;
    logic                    credit_valid;
    logic [VC_W-1:0]         credit_vc;
    logic [NUM_VC*CNT_W-1:0] credit_cnt;
    logic                    locked;
    logic                    credit_err;

    noc_output_port_arbiter #(
        .NUM_IN(NUM_IN), .NUM_VC(NUM_VC), .VC_W(VC_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .noc_clk(clk), .noc_rst_n(rst_n),
        .req(req), .req_vc(req_vc), .req_head(req_head), .req_tail(req_tail),
        .gnt(gnt), .out_valid(out_valid), .out_vc(out_vc),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .credit_cnt(credit_cnt), .locked(locked), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] v, input logic [4:0] h,
                         input logic [4:0] t, input logic cv, input logic cvc);
        req = r; req_vc = v; req_head = h; req_tail = t;
        credit_valid = cv; credit_vc = cvc;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int cred_of(input int v);
        logic [NUM_VC*CNT_W-1:0] c;
        c = credit_cnt;
        return int'(c[v*CNT_W +: CNT_W]);
    endfunction

    typedef struct {
        logic [4:0] req;
        logic [4:0] vc;
        logic [4:0] head;
        logic [4:0] tail;
        logic       cv;
        logic       cvc;
        logic [4:0] exp_gnt;
        logic       exp_vc;
        logic       exp_locked;
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference state: 0 idle, 1 locked, 2 post-tail gap.
    int m_mode, m_owner, m_lvc, m_rr;
    int m_cred[NUM_VC];
    bit m_err;

    initial begin
        drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0);

        // Alternating single-flit packets, then a 3-flit vc1 packet against a waiting head.
        tbl.push_back('{5'b00101, 5'b00000, 5'b00101, 5'b00101, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0});
        tbl.push_back('{5'b00101, 5'b00000, 5'b00101, 5'b00101, 1'b1, 1'b0, 5'b00100, 1'b0, 1'b0});
        tbl.push_back('{5'b00101, 5'b00000, 5'b00101, 5'b00101, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0});
        tbl.push_back('{5'b00101, 5'b00000, 5'b00101, 5'b00101, 1'b1, 1'b0, 5'b00100, 1'b0, 1'b0});
        tbl.push_back('{5'b00001, 5'b00000, 5'b00001, 5'b00001, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0});
        tbl.push_back('{5'b01010, 5'b00010, 5'b01010, 5'b01000, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b0});
        tbl.push_back('{5'b01010, 5'b00010, 5'b01000, 5'b01000, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1});
        tbl.push_back('{5'b01010, 5'b00010, 5'b01000, 5'b01010, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1});
        tbl.push_back('{5'b01000, 5'b00000, 5'b01000, 5'b01000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{5'b01000, 5'b00000, 5'b01000, 5'b01000, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0});

        do_reset();
        sample();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_credit", 32'(credit_cnt), 32'({3'd4, 3'd4}));
        check("reset_err", 32'(credit_err), 32'd0);
        next_cycle();

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].vc, tbl[i].head, tbl[i].tail, tbl[i].cv, tbl[i].cvc);
            sample();
            check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
            if (tbl[i].exp_gnt != 5'b0)
                check($sformatf("tbl%0d_vc", i), 32'(out_vc), 32'(tbl[i].exp_vc));
            next_cycle();
        end

        // Credit exhaustion and single-credit refill on vc0.
        do_reset();
        drive(5'b00001, 5'b00000, 5'b00001, 5'b00001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("exhaust_gnt%0d", i), 32'(gnt), 32'b00001);
            next_cycle();
        end
        sample();
        check("exhaust_stall", 32'(gnt), 32'd0);
        check("exhaust_cnt0", 32'(cred_of(0)), 32'd0);
        next_cycle();
        credit_valid = 1'b1;
        sample();
        check("refill_same_cycle", 32'(gnt), 32'd0);
        next_cycle();
        credit_valid = 1'b0;
        sample();
        check("refill_grant", 32'(gnt), 32'b00001);
        check("refill_cnt0", 32'(cred_of(0)), 32'd1);
        next_cycle();
        sample();
        check("refill_stall", 32'(gnt), 32'd0);
        check("refill_cnt0_zero", 32'(cred_of(0)), 32'd0);
        next_cycle();

        // Simultaneous grant and credit return on vc1.
        do_reset();
        drive(5'b00010, 5'b00010, 5'b00010, 5'b00010, 1'b0, 1'b0);
        sample();
        check("vc1_gnt", 32'(gnt), 32'b00010);
        check("vc1_outvc", 32'(out_vc), 32'd1);
        next_cycle();
        sample();
        check("vc1_cnt3", 32'(cred_of(1)), 32'd3);
        credit_valid = 1'b1; credit_vc = 1'b1;
        #1;
        check("vc1_gnt_again", 32'(gnt), 32'b00010);
        next_cycle();
        drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        sample();
        check("vc1_cnt_hold", 32'(cred_of(1)), 32'd3);
        check("vc1_no_err", 32'(credit_err), 32'd0);
        next_cycle();

        // Credit overflow is sticky.
        do_reset();
        drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b1, 1'b0);
        sample();
        check("ovf_err_before", 32'(credit_err), 32'd0);
        next_cycle();
        credit_valid = 1'b0;
        sample();
        check("ovf_cnt0", 32'(cred_of(0)), 32'd4);
        check("ovf_err", 32'(credit_err), 32'd1);
        next_cycle();
        next_cycle();
        sample();
        check("ovf_err_sticky", 32'(credit_err), 32'd1);
        next_cycle();

        // Reset in the middle of a locked packet.
        do_reset();
        drive(5'b00010, 5'b00000, 5'b00010, 5'b00000, 1'b0, 1'b0);
        sample();
        check("mid_head_gnt", 32'(gnt), 32'b00010);
        next_cycle();
        req_head = 5'b0;
        sample();
        check("mid_body_locked", 32'(locked), 32'd1);
        check("mid_body_gnt", 32'(gnt), 32'b00010);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_credit", 32'(credit_cnt), 32'({3'd4, 3'd4}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(5'b10001, 5'b00000, 5'b10001, 5'b10001, 1'b0, 1'b0);
        sample();
        check("post_rst_rr", 32'(gnt), 32'b00001);
        next_cycle();

        // Randomized run against the reference model.
        do_reset();
        m_mode = 0; m_owner = 0; m_lvc = 0; m_rr = 0; m_err = 1'b0;
        for (int v = 0; v < NUM_VC; v++) m_cred[v] = BUF_DEPTH;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [4:0] eg;
            int evc, win;
            bit fnd;
            drive(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom));
            sample();
            eg = '0; evc = 0; win = 0; fnd = 1'b0;
            if (m_mode == 0) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    int i;
                    i = (m_rr + k) % NUM_IN;
                    if (!fnd && req[i] && req_head[i] && m_cred[int'(req_vc[i])] > 0) begin
                        fnd = 1'b1; win = i; evc = int'(req_vc[i]);
                    end
                end
            end else if (m_mode == 1) begin
                if (req[m_owner] && m_cred[m_lvc] > 0) begin
                    fnd = 1'b1; win = m_owner; evc = m_lvc;
                end
            end
            if (fnd) eg[win] = 1'b1;
            check("rnd_gnt", 32'(gnt), 32'(eg));
            check("rnd_valid", 32'(out_valid), 32'(fnd));
            if (fnd) check("rnd_vc", 32'(out_vc), 32'(evc));
            check("rnd_locked", 32'(locked), 32'(m_mode == 1));
            check("rnd_cnt0", 32'(cred_of(0)), 32'(m_cred[0]));
            check("rnd_cnt1", 32'(cred_of(1)), 32'(m_cred[1]));
            check("rnd_err", 32'(credit_err), 32'(m_err));

            for (int v = 0; v < NUM_VC; v++) begin
                bit d, n;
                d = fnd && (evc == v);
                n = credit_valid && (int'(credit_vc) == v);
                if (d && !n) m_cred[v]--;
                else if (n && !d) begin
                    if (m_cred[v] == BUF_DEPTH) m_err = 1'b1;
                    else m_cred[v]++;
                end
            end
            if (m_mode == 0) begin
                if (fnd) begin
                    m_rr = (win + 1) % NUM_IN;
                    if (!req_tail[win]) begin
                        m_mode = 1; m_owner = win; m_lvc = evc;
                    end
                end
            end else if (m_mode == 1) begin
                if (fnd && req_tail[m_owner]) m_mode = 2;
            end else begin
                m_mode = 0;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
